// File: rtl/regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_write_scheduler
//
// Shares the single register-file write port (PW/RW/E) between two writeback
// requesters. Port 0 is the ALU and port 1 is the load/memory path. A busy
// scoreboard tracks destination registers that have a write reserved but not
// yet committed, so the issue stage can interlock reads.
//
// Optional feature macro: RFSCHED_FIXED_PRIO_EN
//   undefined : round-robin between the ports when both are valid (default)
//   defined   : port 1 always wins a conflict; the last-grant pointer is absent
//
// Ports
//   CLK         in   clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   RSV_VALID   in   reserve request for destination RSV_REG
//   RSV_REG     in   register to reserve
//   RSV_ACCEPT  out  reservation taken this cycle (combinational)
//   REQ0_*      in   port 0 write request: VALID, REG, DATA
//   REQ0_READY  out  grant to port 0 (combinational)
//   REQ1_*      in   port 1 write request: VALID, REG, DATA
//   REQ1_READY  out  grant to port 1 (combinational)
//   PW          out  registered write data
//   RW          out  registered write index
//   E           out  registered write enable, one-cycle pulse per grant
//   BUSY        out  scoreboard, bit r set = register r has a reserved write
//   ERR         out  sticky: a write was granted to an unreserved register
// -----------------------------------------------------------------------------
module regfile_write_scheduler #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 4,
    localparam int NREGS      = 2 ** ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  RSV_VALID,
    input  logic [ADDR_WIDTH-1:0] RSV_REG,
    output logic                  RSV_ACCEPT,
    input  logic                  REQ0_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ0_REG,
    input  logic [DATA_WIDTH-1:0] REQ0_DATA,
    output logic                  REQ0_READY,
    input  logic                  REQ1_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ1_REG,
    input  logic [DATA_WIDTH-1:0] REQ1_DATA,
    output logic                  REQ1_READY,
    output logic [DATA_WIDTH-1:0] PW,
    output logic [ADDR_WIDTH-1:0] RW,
    output logic                  E,
    output logic [NREGS-1:0]      BUSY,
    output logic                  ERR
);

    logic [DATA_WIDTH-1:0] pw_q;
    logic [ADDR_WIDTH-1:0] rw_q;
    logic                  e_q;
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_next;
    logic                  err_q;

    logic                  grant0;
    logic                  grant1;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] grant_reg;
    logic [DATA_WIDTH-1:0] grant_data;

`ifndef RFSCHED_FIXED_PRIO_EN
    // Port that won the most recent grant; reset to 1 so port 0 wins first.
    logic                  last_q;
`endif

    // -------------------------------------------------------------------------
    // Arbitration: at most one grant per cycle.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef RFSCHED_FIXED_PRIO_EN
        grant1 = REQ1_VALID;
        grant0 = REQ0_VALID & ~REQ1_VALID;
`else
        if (REQ0_VALID && REQ1_VALID) begin
            // Round-robin: the port that did not win last time wins now.
            grant0 = last_q;
            grant1 = ~last_q;
        end else begin
            grant0 = REQ0_VALID;
            grant1 = REQ1_VALID;
        end
`endif
        grant      = grant0 | grant1;
        grant_reg  = grant1 ? REQ1_REG  : REQ0_REG;
        grant_data = grant1 ? REQ1_DATA : REQ0_DATA;
    end

    assign REQ0_READY = grant0;
    assign REQ1_READY = grant1;

    // A register whose bit is still set cannot be reserved again, even when
    // its clear happens this very cycle; the issue stage simply retries.
    assign RSV_ACCEPT = RSV_VALID & ~busy_q[RSV_REG];

    // -------------------------------------------------------------------------
    // Scoreboard next state. The clear happens on the edge where the register
    // file captures the write (the cycle E is high), so BUSY[r]=0 means the
    // new value is already readable.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_next = busy_q;
        if (e_q) begin
            busy_next[rw_q] = 1'b0;
        end
        if (RSV_ACCEPT) begin
            busy_next[RSV_REG] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset to
    // drop all reservations; a reset mid-operation also discards the pending
    // registered write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pw_q   <= '0;
            rw_q   <= '0;
            e_q    <= 1'b0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            e_q    <= grant;
            busy_q <= busy_next;
            if (grant) begin
                pw_q <= grant_data;
                rw_q <= grant_reg;
                // The write still proceeds; only the sticky flag records it.
                if (!busy_q[grant_reg]) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

`ifndef RFSCHED_FIXED_PRIO_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= grant1;
        end
    end
`endif

    assign PW   = pw_q;
    assign RW   = rw_q;
    assign E    = e_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;

endmodule
